// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source-side launcher for a 4-phase req/ack clock-domain crossing
//
// Accepts one word from a valid/ready source and holds it on dout. It then raises
// req and waits for the far domain's ack. ack_async is brought in through a
// stages-deep synchronizer. The next word is accepted only after ack has been
// seen to rise and then fall.
//
// Parameters:
//   width      data bus width in bits
//   stages     ack synchronizer depth (2..4)
//
// Ports:
//   clock      in   source-domain clock, rising edge
//   reset      in   synchronous active-high reset
//   din_valid  in   source offers a word
//   din        in   source data [width]
//   din_ready  out  block can accept a word (state is IDLE)
//   dout       out  held data to the far domain [width]
//   req        out  registered request level to the far domain
//   ack_async  in   acknowledge level from the far domain (asynchronous)
//   err        out  sticky protocol-violation flag (only with CDC_HANDSHAKE_TX_ERR_EN)
//
// Optional feature macro: CDC_HANDSHAKE_TX_ERR_EN

module cdc_handshake_tx #(
    parameter int width  = 32,
    parameter int stages = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             din_valid,
    input  logic [width-1:0] din,
    output logic             din_ready,
    output logic [width-1:0] dout,
    output logic             req,
    input  logic             ack_async
`ifdef CDC_HANDSHAKE_TX_ERR_EN
    ,
    output logic             err
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ_HI = 2'd1;
    localparam logic [1:0] ST_REQ_LO = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic [width-1:0]  dout_q, dout_d;
    logic [stages-1:0] sync_q;
    logic              ack_sync;

    // Plain flop chain. Nothing may sit between stages, because each stage
    // gives a metastable sample time to resolve.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[stages-2:0], ack_async};
        end
    end

    assign ack_sync = sync_q[stages-1];

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                // A spurious or late ack seen here is ignored.
                if (din_valid) begin
                    state_d = ST_REQ_HI;
                    req_d   = 1'b1;
                    dout_d  = din;
                end
            end
            ST_REQ_HI: begin
                if (ack_sync) begin
                    state_d = ST_REQ_LO;
                    req_d   = 1'b0;
                end
            end
            ST_REQ_LO: begin
                // Wait for the far side to drop ack, which completes the 4-phase cycle.
                if (!ack_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            dout_q  <= dout_d;
        end
    end

    // Derived from the state register alone, so there is no path from din_valid.
    assign din_ready = (state_q == ST_IDLE);
    assign req       = req_q;
    assign dout      = dout_q;

`ifdef CDC_HANDSHAKE_TX_ERR_EN
    logic err_q, err_d;

    // Sticky. An ack in IDLE means the far side is out of step with us.
    always_comb begin
        err_d = err_q | ((state_q == ST_IDLE) && ack_sync);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - self-checking bench for cdc_handshake_tx

module tb_cdc_handshake_tx;

    localparam int W  = 32;
    localparam int ST = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          din_valid;
    logic [W-1:0]  din;
    logic          din_ready;
    logic [W-1:0]  dout;
    logic          req;
    logic          ack_async;

    logic          din_valid3;
    logic [W-1:0]  din3;
    logic          din_ready3;
    logic [W-1:0]  dout3;
    logic          req3;
    logic          ack3;
`ifdef CDC_HANDSHAKE_TX_ERR_EN
    logic          err;
    logic          err3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Inputs to the main DUT come either from directed code or from the random agents.
    logic          src_en = 1'b0, src_rand = 1'b0, src_valid = 1'b0, src_pend = 1'b0;
    logic [W-1:0]  src_data = '0;
    logic [W-1:0]  src_q[$];
    logic          resp_en = 1'b0, resp_rand = 1'b0, resp_ack = 1'b0;
    int            resp_cnt = 0, resp_delay = 4;
    logic          dir_valid, dir_ack;
    logic [W-1:0]  dir_data;

    assign din_valid = src_en  ? src_valid : dir_valid;
    assign din       = src_en  ? src_data  : dir_data;
    assign ack_async = resp_en ? resp_ack  : dir_ack;

    always #5 clock = ~clock;

    cdc_handshake_tx #(.width(W), .stages(ST)) u_dut (
        .clock(clock), .reset(reset), .din_valid(din_valid), .din(din),
        .din_ready(din_ready), .dout(dout), .req(req), .ack_async(ack_async)
`ifdef CDC_HANDSHAKE_TX_ERR_EN
        , .err(err)
`endif
    );

    cdc_handshake_tx #(.width(W), .stages(3)) u_dut3 (
        .clock(clock), .reset(reset), .din_valid(din_valid3), .din(din3),
        .din_ready(din_ready3), .dout(dout3), .req(req3), .ack_async(ack3)
`ifdef CDC_HANDSHAKE_TX_ERR_EN
        , .err(err3)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ack_sync is ack_async delayed by ST edges. A transfer
    // starts when a word is offered while not busy. req drops once the delayed
    // ack is seen high. The block is free again once the delayed ack is seen low.
    bit            m_valid = 0;
    bit            m_busy, m_acked, m_req, m_err;
    logic [W-1:0]  m_dout;
    bit            m_hist[$];
    logic [W-1:0]  acc_q[$];
    logic [W-1:0]  rise_log[$];
    int            rise_cnt = 0;
    logic          prev_req = 1'b0;

    always @(posedge clock) begin
        bit a_sync;
        if (reset) begin
            m_valid = 1; m_busy = 0; m_acked = 0; m_req = 0; m_err = 0; m_dout = '0;
            m_hist.delete();
            repeat (ST) m_hist.push_back(1'b0);
            acc_q.delete();
        end else if (m_valid) begin
            a_sync = m_hist[0];
            if (!m_busy) begin
                if (a_sync) m_err = 1;
                if (din_valid) begin
                    m_busy = 1; m_acked = 0; m_req = 1; m_dout = din;
                    acc_q.push_back(din);
                end
            end else if (!m_acked) begin
                if (a_sync) begin m_acked = 1; m_req = 0; end
            end else if (!a_sync) begin
                m_busy = 0;
            end
            void'(m_hist.pop_front());
            m_hist.push_back(ack_async);
        end
        #1;
        if (m_valid) begin
            check("din_ready", din_ready, !m_busy);
            check("req", req, m_req);
            check("dout", dout, m_dout);
`ifdef CDC_HANDSHAKE_TX_ERR_EN
            check("err", err, m_err);
`endif
            if (req === 1'b1 && prev_req === 1'b0) begin
                rise_cnt++;
                rise_log.push_back(dout);
                if (acc_q.size() == 0) begin
                    check("xfer_unexpected", 1, 0);
                end else begin
                    check("xfer_order", dout, acc_q.pop_front());
                end
            end
            prev_req = req;
        end
    end

    // Source agent: holds each word until the edge that accepts it.
    always @(negedge clock) begin
        if (src_en) begin
            if (src_pend) begin
                void'(src_q.pop_front());
                src_valid = 1'b0;
                src_pend  = 1'b0;
            end
            if (!src_valid && src_q.size() > 0 && (!src_rand || $urandom_range(0, 1) == 1)) begin
                src_valid = 1'b1;
                src_data  = src_q[0];
            end
            if (src_valid && din_ready) src_pend = 1'b1;
        end
    end

    // Destination agent: mirrors req onto ack after a delay.
    always @(negedge clock) begin
        if (resp_en) begin
            if (req !== resp_ack) begin
                resp_cnt++;
                if (resp_cnt >= resp_delay) begin
                    resp_ack   = req;
                    resp_cnt   = 0;
                    resp_delay = resp_rand ? int'($urandom_range(0, 5)) : 4;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (src_q.size() == 0 && !src_valid && !src_pend && din_ready && !req && !ack_async) break;
            tick();
        end
        if (i == budget) check("idle_timeout", 1, 0);
    endtask

    initial begin
        int base;
        reset = 1'b1; dir_valid = 1'b1; dir_data = 32'h1234_5678; dir_ack = 1'b0;
        din_valid3 = 1'b0; din3 = '0; ack3 = 1'b0;

        // Reset held with din_valid high: nothing is accepted.
        repeat (3) begin
            tick();
            check("rst_req", req, 0);
            check("rst_dout", dout, 0);
            check("rst_ready", din_ready, 1);
        end
        dir_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Single transfer with the edge numbering of the test plan.
        dir_data = 32'hDEAD_BEEF; dir_valid = 1'b1;
        tick();
        check("st_req_e0", req, 1);
        check("st_dout_e0", dout, 32'hDEAD_BEEF);
        check("st_ready_e0", din_ready, 0);
        dir_valid = 1'b0; dir_ack = 1'b1;
        tick(); check("st_req_e1", req, 1);
        tick(); check("st_req_e2", req, 1);
        tick(); check("st_req_e3", req, 0);
        tick();
        dir_ack = 1'b0;
        tick(); check("st_ready_e5", din_ready, 0);
        tick(); check("st_ready_e6", din_ready, 0);
        tick(); check("st_ready_e7", din_ready, 1);
        check("st_dout_idle", dout, 32'hDEAD_BEEF);

        // Spurious ack in IDLE.
        dir_ack = 1'b1;
        tick(); tick();
`ifdef CDC_HANDSHAKE_TX_ERR_EN
        check("sp_err_early", err, 0);
`endif
        tick();
`ifdef CDC_HANDSHAKE_TX_ERR_EN
        check("sp_err_set", err, 1);
`endif
        dir_ack = 1'b0;
        repeat (4) tick();
        check("sp_req", req, 0);
        check("sp_ready", din_ready, 1);
`ifdef CDC_HANDSHAKE_TX_ERR_EN
        check("sp_err_sticky", err, 1);
`endif
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
`ifdef CDC_HANDSHAKE_TX_ERR_EN
        check("sp_err_cleared", err, 0);
`endif

        // Backpressure: three queued words, fixed ack delay of 4.
        rise_log.delete();
        src_q = '{32'h1, 32'h2, 32'h3};
        src_rand = 1'b0; resp_rand = 1'b0; resp_delay = 4;
        src_en = 1'b1; resp_en = 1'b1;
        tick();
        wait_idle(500);
        check("bp_count", rise_log.size(), 3);
        if (rise_log.size() == 3) begin
            check("bp_w0", rise_log[0], 32'h1);
            check("bp_w1", rise_log[1], 32'h2);
            check("bp_w2", rise_log[2], 32'h3);
        end

        // Randomized traffic and response delays.
        src_rand = 1'b1; resp_rand = 1'b1;
        base = rise_cnt;
        for (int i = 0; i < 40; i++) src_q.push_back($urandom);
        tick();
        wait_idle(4000);
        check("rand_count", rise_cnt - base, 40);
        check("rand_pending", acc_q.size(), 0);
        src_en = 1'b0; resp_en = 1'b0; resp_ack = 1'b0;
        dir_valid = 1'b0; dir_ack = 1'b0;
        tick(); tick();

        // Reset mid-transfer, then a new transfer with ack still high.
        dir_data = 32'hCAFE_0001; dir_valid = 1'b1;
        tick(); check("mr_req", req, 1);
        dir_valid = 1'b0; dir_ack = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("mr_rst_req", req, 0);
        check("mr_rst_dout", dout, 0);
        reset = 1'b0; dir_data = 32'hCAFE_0002; dir_valid = 1'b1;
        tick();
        check("mr_acc_req", req, 1);
        check("mr_acc_dout", dout, 32'hCAFE_0002);
        dir_valid = 1'b0;
        tick(); check("mr_hold", req, 1);
        tick(); check("mr_lo", req, 0);
        dir_ack = 1'b0;
        tick(); tick(); check("mr_not_idle", din_ready, 0);
        tick(); check("mr_idle", din_ready, 1);

        // stages=3: req falls four edges after ack rises.
        din3 = 32'h0BAD_F00D; din_valid3 = 1'b1;
        tick();
        check("s3_req_e0", req3, 1);
        check("s3_dout", dout3, 32'h0BAD_F00D);
        din_valid3 = 1'b0; ack3 = 1'b1;
        tick(); tick(); tick();
        check("s3_req_e3", req3, 1);
        tick(); check("s3_req_e4", req3, 0);
        ack3 = 1'b0;
        tick(); tick(); tick();
        check("s3_ready_e7", din_ready3, 0);
        tick(); check("s3_ready_e8", din_ready3, 1);
`ifdef CDC_HANDSHAKE_TX_ERR_EN
        check("s3_err", err3, 0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
